// File: rtl/anita4_trig_pkg.sv
// ---------------------------------------------------------------------------
// anita4_trig_pkg
// Purpose : shared definitions for the ANITA-4 trigger buffer manager.
//           Holds the default trigger/buffer counts, the buffer manager FSM
//           state type and a constant-evaluable clog2 helper.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package anita4_trig_pkg;

  localparam int DEFAULT_NUM_TRIG    = 4;
  localparam int DEFAULT_NUM_BUFFERS = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    HOLDOFF = 1'b1
  } state_t;

  // Smallest r with 2**r >= n; used to size buffer indices.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/anita4_buffer_manager_if.sv
// ---------------------------------------------------------------------------
// anita4_buffer_manager_if
// Purpose : groups the trigger request, buffer clear and digitize/status
//           signals of the buffer manager.
// Modports: master - trigger/clear source (drives *_i, observes *_o)
//           slave  - the buffer manager itself
// Signals : trig_i, trig_mask_i, holdoff_i, clear_i, clear_buffer_i,
//           digitize_o, digitize_buffer_o, digitize_source_o,
//           buffer_status_o, HOLD_o, dead_o, lost_o,
//           dead_count_o (only with BUFMGR_DEADTIME_COUNTER_EN defined)
// ---------------------------------------------------------------------------
interface anita4_buffer_manager_if #(
  parameter int NUM_TRIG    = anita4_trig_pkg::DEFAULT_NUM_TRIG,
  parameter int NUM_BUFFERS = anita4_trig_pkg::DEFAULT_NUM_BUFFERS,
  parameter int BUF_W       = anita4_trig_pkg::clog2(NUM_BUFFERS)
);

  logic [NUM_TRIG-1:0]    trig_i;
  logic [NUM_TRIG-1:0]    trig_mask_i;
  logic [7:0]             holdoff_i;
  logic                   clear_i;
  logic [BUF_W-1:0]       clear_buffer_i;
  logic                   digitize_o;
  logic [BUF_W-1:0]       digitize_buffer_o;
  logic [NUM_TRIG-1:0]    digitize_source_o;
  logic [NUM_BUFFERS-1:0] buffer_status_o;
  logic [NUM_BUFFERS-1:0] HOLD_o;
  logic                   dead_o;
  logic                   lost_o;
`ifdef BUFMGR_DEADTIME_COUNTER_EN
  logic [31:0]            dead_count_o;
`endif

  modport master (
    output trig_i, trig_mask_i, holdoff_i, clear_i, clear_buffer_i,
    input  digitize_o, digitize_buffer_o, digitize_source_o,
    input  buffer_status_o, HOLD_o, dead_o, lost_o
`ifdef BUFMGR_DEADTIME_COUNTER_EN
    , input dead_count_o
`endif
  );

  modport slave (
    input  trig_i, trig_mask_i, holdoff_i, clear_i, clear_buffer_i,
    output digitize_o, digitize_buffer_o, digitize_source_o,
    output buffer_status_o, HOLD_o, dead_o, lost_o
`ifdef BUFMGR_DEADTIME_COUNTER_EN
    , output dead_count_o
`endif
  );

endinterface

// File: rtl/anita4_free_buffer_finder.sv
// ---------------------------------------------------------------------------
// anita4_free_buffer_finder
// Purpose : combinational search for the first free buffer, scanning upward
//           from next_ptr_i and wrapping modulo NUM_BUFFERS.
// Ports   : status_i   - busy flags, 1 = busy
//           next_ptr_i - index where the scan starts
//           found_o    - at least one buffer is free
//           index_o    - first free index at or after next_ptr_i
// ---------------------------------------------------------------------------
module anita4_free_buffer_finder #(
  parameter int NUM_BUFFERS = anita4_trig_pkg::DEFAULT_NUM_BUFFERS,
  parameter int BUF_W       = anita4_trig_pkg::clog2(NUM_BUFFERS)
) (
  input  logic [NUM_BUFFERS-1:0] status_i,
  input  logic [BUF_W-1:0]       next_ptr_i,
  output logic                   found_o,
  output logic [BUF_W-1:0]       index_o
);

  logic [BUF_W-1:0] w_cand;

  // Scan offsets from the far end back to zero so the last hit written is
  // the one closest to next_ptr_i. BUF_W-bit addition wraps naturally since
  // NUM_BUFFERS is a power of two.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    w_cand  = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      w_cand = next_ptr_i + BUF_W'(i);
      if (!status_i[w_cand]) begin
        found_o = 1'b1;
        index_o = w_cand;
      end
    end
  end

endmodule

// File: rtl/anita4_buffer_manager.sv
// ---------------------------------------------------------------------------
// anita4_buffer_manager
// Purpose : accepts rising-edge trigger requests, allocates a free SURF
//           analog buffer round-robin, emits a digitize pulse, applies a
//           programmable holdoff and tracks busy buffers until cleared.
// Ports   : clk250_i - sole clock (rising edge)
//           rst_i    - asynchronous active-high reset
//           bm       - anita4_buffer_manager_if.slave bundle (trigger,
//                      mask, holdoff, clear inputs; digitize, status, HOLD,
//                      dead, lost outputs)
// Options : BUFMGR_DEADTIME_COUNTER_EN adds bm.dead_count_o, a saturating
//           32-bit count of cycles with dead_o high.
// ---------------------------------------------------------------------------
module anita4_buffer_manager #(
  parameter int NUM_TRIG    = anita4_trig_pkg::DEFAULT_NUM_TRIG,
  parameter int NUM_BUFFERS = anita4_trig_pkg::DEFAULT_NUM_BUFFERS,
  parameter int BUF_W       = anita4_trig_pkg::clog2(NUM_BUFFERS)
) (
  input  logic                    clk250_i,
  input  logic                    rst_i,
  anita4_buffer_manager_if.slave  bm
);

  import anita4_trig_pkg::*;

  state_t                 r_state;
  logic [NUM_TRIG-1:0]    r_trig_q;
  logic [NUM_TRIG-1:0]    r_dig_src;
  logic [BUF_W-1:0]       r_dig_buf;
  logic [BUF_W-1:0]       r_next_ptr;
  logic [NUM_BUFFERS-1:0] r_status;
  logic [7:0]             r_hold_cnt;
  logic                   r_digitize;
  logic                   r_dead;
  logic                   r_lost;

  logic [NUM_TRIG-1:0]    w_edge;
  logic                   w_found;
  logic [BUF_W-1:0]       w_idx;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_hold_nxt;
  logic [NUM_BUFFERS-1:0] w_status_nxt;

  assign w_edge = bm.trig_i & ~r_trig_q & bm.trig_mask_i;

  // The finder sees the registered status, so a buffer freed by a clear in
  // this cycle only becomes eligible next cycle.
  anita4_free_buffer_finder #(
    .NUM_BUFFERS (NUM_BUFFERS),
    .BUF_W       (BUF_W)
  ) u_finder (
    .status_i   (r_status),
    .next_ptr_i (r_next_ptr),
    .found_o    (w_found),
    .index_o    (w_idx)
  );

  assign w_accept = (r_state == IDLE) && (|w_edge) && w_found;
  assign w_drop   = (|w_edge) && !w_accept;

  // FSM is in HOLDOFF next cycle either on a fresh accept with nonzero
  // holdoff, or while the count has not yet reached its final cycle.
  assign w_hold_nxt = (w_accept && (bm.holdoff_i != 8'd0)) ||
                      ((r_state == HOLDOFF) && (r_hold_cnt > 8'd1));

  // Clear first, then allocation, so allocation wins on the same index.
  always_comb begin
    w_status_nxt = r_status;
    if (bm.clear_i) w_status_nxt[bm.clear_buffer_i] = 1'b0;
    if (w_accept)   w_status_nxt[w_idx] = 1'b1;
  end

  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_trig_q   <= '0;
      r_dig_src  <= '0;
      r_dig_buf  <= '0;
      r_next_ptr <= '0;
      r_status   <= '0;
      r_hold_cnt <= 8'd0;
      r_digitize <= 1'b0;
      r_dead     <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_trig_q   <= bm.trig_i;
      r_status   <= w_status_nxt;
      r_digitize <= w_accept;
      r_lost     <= w_drop;
      // Registered from next-state values so dead lines up with status.
      r_dead     <= w_hold_nxt | (&w_status_nxt);

      if (w_accept) begin
        r_dig_buf  <= w_idx;
        r_dig_src  <= w_edge;
        r_next_ptr <= w_idx + BUF_W'(1);
      end

      case (r_state)
        IDLE: begin
          if (w_accept && (bm.holdoff_i != 8'd0)) begin
            r_state    <= HOLDOFF;
            r_hold_cnt <= bm.holdoff_i;
          end
        end
        HOLDOFF: begin
          if (r_hold_cnt <= 8'd1) begin
            r_state    <= IDLE;
            r_hold_cnt <= 8'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_hold_cnt <= 8'd0;
        end
      endcase
    end
  end

  assign bm.digitize_o        = r_digitize;
  assign bm.digitize_buffer_o = r_dig_buf;
  assign bm.digitize_source_o = r_dig_src;
  assign bm.buffer_status_o   = r_status;
  assign bm.HOLD_o            = r_status;
  assign bm.dead_o            = r_dead;
  assign bm.lost_o            = r_lost;

`ifdef BUFMGR_DEADTIME_COUNTER_EN
  logic [31:0] r_dead_count;

  // Zeroing is only honoured when every buffer is free, so software can
  // restart the measurement without racing live events.
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      r_dead_count <= 32'd0;
    end else if (bm.clear_i && (bm.clear_buffer_i == '0) && (r_status == '0)) begin
      r_dead_count <= 32'd0;
    end else if (r_dead && (r_dead_count != 32'hFFFF_FFFF)) begin
      r_dead_count <= r_dead_count + 32'd1;
    end
  end

  assign bm.dead_count_o = r_dead_count;
`endif

endmodule

// File: tb/tb_anita4_buffer_manager.sv
// ---------------------------------------------------------------------------
// tb_anita4_buffer_manager
// Purpose : directed scoreboard bench for anita4_buffer_manager. Stimulus
//           pushes expected digitize (buffer, source) and lost events into
//           queues; a monitor pops and compares whenever the DUT pulses.
// ---------------------------------------------------------------------------
module tb_anita4_buffer_manager;

  localparam int NT = 4;
  localparam int NB = 4;
  localparam int BW = 2;

  typedef struct packed {
    logic [BW-1:0] b;
    logic [NT-1:0] s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  exp_t q_dig[$];
  bit   q_lost[$];
  exp_t mon_e;
  int   dcnt;

  always #5 clk = ~clk;

  anita4_buffer_manager_if #(.NUM_TRIG(NT), .NUM_BUFFERS(NB), .BUF_W(BW)) bm ();

  anita4_buffer_manager #(.NUM_TRIG(NT), .NUM_BUFFERS(NB), .BUF_W(BW)) dut (
    .clk250_i (clk),
    .rst_i    (rst),
    .bm       (bm)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bm.trig_i = '0;
    bm.clear_i = 1'b0;
    bm.clear_buffer_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic expect_dig(input int b, input int s);
    q_dig.push_back('{b: BW'(b), s: NT'(s)});
  endtask

  // One-cycle request followed by one low cycle so the next pulse is an edge.
  task automatic trig_pulse(input int v);
    bm.trig_i = NT'(v);
    tick();
    bm.trig_i = '0;
    tick();
  endtask

  task automatic clear_buf(input int b);
    bm.clear_i = 1'b1;
    bm.clear_buffer_i = BW'(b);
    tick();
    bm.clear_i = 1'b0;
  endtask

  // Monitor: compare every digitize and lost pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bm.digitize_o) begin
        if (q_dig.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_digitize: got buf=%0d src=0x%0h expected no pulse",
                   bm.digitize_buffer_o, bm.digitize_source_o);
        end else begin
          mon_e = q_dig.pop_front();
          chk("dig_buf", int'(bm.digitize_buffer_o), int'(mon_e.b));
          chk("dig_src", int'(bm.digitize_source_o), int'(mon_e.s));
        end
      end
      if (bm.lost_o) begin
        if (q_lost.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_lost: got lost_o=1 expected 0 at %0t", $time);
        end else begin
          void'(q_lost.pop_front());
          n_vec++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bm.trig_i = '0;
    bm.trig_mask_i = '1;
    bm.holdoff_i = 8'd0;
    bm.clear_i = 1'b0;
    bm.clear_buffer_i = '0;

    // Reset state
    #2;
    chk("rst_digitize", int'(bm.digitize_o), 0);
    chk("rst_status", int'(bm.buffer_status_o), 0);
    chk("rst_hold", int'(bm.HOLD_o), 0);
    chk("rst_dead", int'(bm.dead_o), 0);
    chk("rst_lost", int'(bm.lost_o), 0);
    chk("rst_dig_buf", int'(bm.digitize_buffer_o), 0);
    chk("rst_dig_src", int'(bm.digitize_source_o), 0);
    do_reset();

    // Single trigger, holdoff 0
    expect_dig(0, 'b0001);
    trig_pulse('b0001);
    @(negedge clk);
    chk("A_status", int'(bm.buffer_status_o), 'b0001);
    chk("A_hold", int'(bm.HOLD_o), 'b0001);
    chk("A_dead", int'(bm.dead_o), 0);

    // Fill all four buffers, then a fifth edge is lost
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expect_dig(k, 'b0001);
      trig_pulse('b0001);
      tick();
      tick();
    end
    @(negedge clk);
    chk("B_status_full", int'(bm.buffer_status_o), 'hF);
    chk("B_dead_full", int'(bm.dead_o), 1);
    q_lost.push_back(1'b1);
    trig_pulse('b0001);

    // Clear buffer 2 with all busy and next_ptr=0: buffer 2 reallocated
    clear_buf(2);
    @(negedge clk);
    chk("C_status_clr2", int'(bm.buffer_status_o), 'b1011);
    chk("C_dead_clr2", int'(bm.dead_o), 0);
    expect_dig(2, 'b0001);
    trig_pulse('b0001);
    // next_ptr is now 3: with 0 and 3 free, 3 must be chosen
    clear_buf(0);
    clear_buf(3);
    expect_dig(3, 'b0001);
    trig_pulse('b0001);
    expect_dig(0, 'b0001);
    trig_pulse('b0001);

    // Simultaneous clear and trigger with all busy: edge lost, clear applied
    bm.clear_i = 1'b1;
    bm.clear_buffer_i = 2'd1;
    bm.trig_i = 4'b0001;
    q_lost.push_back(1'b1);
    tick();
    bm.clear_i = 1'b0;
    bm.trig_i = '0;
    @(negedge clk);
    chk("C_status_simul", int'(bm.buffer_status_o), 'b1101);
    tick();
    expect_dig(1, 'b0001);
    trig_pulse('b0001);

    // Clear of the buffer being allocated is overridden by the allocation
    clear_buf(3);
    bm.clear_i = 1'b1;
    bm.clear_buffer_i = 2'd3;
    bm.trig_i = 4'b0001;
    expect_dig(3, 'b0001);
    tick();
    bm.clear_i = 1'b0;
    bm.trig_i = '0;
    @(negedge clk);
    chk("C_status_alloc_wins", int'(bm.buffer_status_o), 'hF);
    tick();

    // Holdoff 5: edge at accept+1 lost, edge at accept+6 accepted
    do_reset();
    bm.holdoff_i = 8'd5;
    dcnt = 0;
    expect_dig(0, 'b0001);
    bm.trig_i = 4'b0001;
    tick();
    bm.trig_i = 4'b0010;
    q_lost.push_back(1'b1);
    @(negedge clk);
    if (bm.dead_o) dcnt++;
    tick();
    bm.trig_i = '0;
    @(negedge clk);
    if (bm.dead_o) dcnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      if (bm.dead_o) dcnt++;
    end
    tick();
    bm.trig_i = 4'b0100;
    expect_dig(1, 'b0100);
    @(negedge clk);
    if (bm.dead_o) dcnt++;
    chk("D_dead_cycles", dcnt, 5);
    tick();
    bm.trig_i = '0;
    repeat (8) tick();
    bm.holdoff_i = 8'd0;

    // Masked source and a held level give exactly one digitize
    do_reset();
    bm.trig_mask_i = 4'b0100;
    expect_dig(0, 'b0100);
    bm.trig_i = 4'b0110;
    repeat (20) tick();
    bm.trig_i = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("E_digitize_idle", int'(bm.digitize_o), 0);
    chk("E_buf_held", int'(bm.digitize_buffer_o), 0);
    chk("E_src_held", int'(bm.digitize_source_o), 'b0100);
    bm.trig_mask_i = '1;

    // Reset in the middle of a long holdoff discards everything
    do_reset();
    bm.holdoff_i = 8'd50;
    expect_dig(0, 'b0001);
    trig_pulse('b0001);
    repeat (2) tick();
    @(negedge clk);
    chk("F_dead_pre", int'(bm.dead_o), 1);
    chk("F_status_pre", int'(bm.buffer_status_o), 'b0001);
    rst = 1'b1;
    #1;
    chk("F_status_async", int'(bm.buffer_status_o), 0);
    chk("F_dead_async", int'(bm.dead_o), 0);
    do_reset();
    bm.holdoff_i = 8'd0;
    repeat (10) tick();
    expect_dig(0, 'b0010);
    trig_pulse('b0010);

`ifdef BUFMGR_DEADTIME_COUNTER_EN
    // Dead-time counter: 100 cycles fully busy, then zeroed
    do_reset();
    for (int k = 0; k < 4; k++) begin
      expect_dig(k, 'b0001);
      trig_pulse('b0001);
    end
    repeat (99) tick();
    @(negedge clk);
    chk("G_dead_count_100", int'(bm.dead_count_o), 100);
    for (int k = 0; k < 4; k++) clear_buf(k);
    clear_buf(0);
    @(negedge clk);
    chk("G_dead_count_zero", int'(bm.dead_count_o), 0);
`endif

    repeat (5) tick();
    chk("dig_queue_empty", q_dig.size(), 0);
    chk("lost_queue_empty", q_lost.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anita4_buffer_manager.md
ANITA4_BUFFER_MANAGER -- requirements
Module: anita4_buffer_manager

Interface
REQ-001 Parameter NUM_TRIG, default 4: number of trigger sources (1..8).
REQ-002 Parameter NUM_BUFFERS, default 4: number of SURF analog buffers (power of two, 2..8).
REQ-003 Parameter BUF_W, default 2: buffer index width, equal to clog2(NUM_BUFFERS).
REQ-004 clk250_i  in  1  sole clock; all logic is on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 trig_i  in  NUM_TRIG  trigger requests; bit 0 has the highest priority.
REQ-007 trig_mask_i  in  NUM_TRIG  per-source enable; 1 = enabled.
REQ-008 holdoff_i  in  8  holdoff length in clocks applied after each accepted trigger.
REQ-009 clear_i  in  1  single-cycle pulse that frees a buffer.
REQ-010 clear_buffer_i  in  BUF_W  index of the buffer to free.
REQ-011 digitize_o  out  1  single-cycle pulse marking an accepted trigger.
REQ-012 digitize_buffer_o  out  BUF_W  buffer allocated to the accepted trigger.
REQ-013 digitize_source_o  out  NUM_TRIG  all masked rising edges captured in the accept cycle.
REQ-014 buffer_status_o  out  NUM_BUFFERS  1 = buffer is busy.
REQ-015 HOLD_o  out  NUM_BUFFERS  hold for each buffer; equal to buffer_status_o.
REQ-016 dead_o  out  1  trigger inhibited.
REQ-017 lost_o  out  1  single-cycle pulse when a masked rising edge is dropped.

Function
REQ-018 Triggers are rising-edge detected: register trig_i, then form edge = trig_i & ~trig_q & trig_mask_i; a held level does not retrigger.
REQ-019 FSM has two states. IDLE: accept when edge is non-zero and a free buffer exists. HOLDOFF: count down, then return to IDLE.
REQ-020 Accept in cycle N gives, in cycle N+1: digitize_o=1, digitize_buffer_o = allocated index, digitize_source_o = edge, and the allocated status/HOLD bit set to 1.
REQ-021 Allocation is the first free buffer found scanning upward from next_ptr, modulo NUM_BUFFERS.
REQ-022 After an accept, next_ptr = allocated index + 1, wrapping from NUM_BUFFERS-1 to 0.
REQ-023 Holdoff value is latched at accept; a nonzero value H keeps the FSM in HOLDOFF for H clocks after the digitize cycle; H=0 returns to IDLE with no holdoff cycle.
REQ-024 dead_o = (state==HOLDOFF) OR (all buffers busy); it is registered and aligned with the status bits.
REQ-025 An edge arriving while in HOLDOFF or while all buffers are busy is dropped, and lost_o pulses in the next cycle.
REQ-026 clear_i clears status bit clear_buffer_i in the next cycle; clearing a buffer that is already free has no effect.
REQ-027 Simultaneous clear and trigger: the clear is applied, but the freed buffer is not eligible for allocation until the following cycle.
REQ-028 Clearing the buffer being allocated in the same cycle is a no-op for that buffer; the allocation wins.
REQ-029 digitize_buffer_o and digitize_source_o hold their last values between pulses.

Reset
REQ-030 On rst_i, asynchronously: state=IDLE, next_ptr=0, all status/HOLD bits 0, trig_q=0, holdoff count 0, digitize_o=0, lost_o=0, dead_o=0, digitize_buffer_o=0, digitize_source_o=0.
REQ-031 Reset asserted mid-holdoff or with busy buffers discards all state; no digitize_o pulse is produced after release.

Configuration
REQ-032 With macro BUFMGR_DEADTIME_COUNTER_EN defined: add output dead_count_o (32 bits), a saturating count of cycles with dead_o=1, reset to 0 and zeroed by a clear_i with clear_buffer_i=0 when all buffers are free.
REQ-033 With BUFMGR_DEADTIME_COUNTER_EN undefined: dead_count_o and its counter are absent; all other behaviour is identical.

Structure
REQ-034 Shared package anita4_trig_pkg holds the clog2 function, the FSM state typedef (IDLE, HOLDOFF) and the default NUM_TRIG/NUM_BUFFERS constants.
REQ-035 One combinational sub-module, anita4_free_buffer_finder, takes status and next_ptr and returns found and index; all sequential logic stays in the top level.

Verification
REQ-036 Reset, then trig_i=0001 with mask 1111 and holdoff 0: digitize_o one cycle later, buffer 0, source 0001, status 0001.
REQ-037 Four single-cycle triggers 4 clocks apart, no clears: buffers 0,1,2,3 allocated, dead_o=1; a fifth edge gives lost_o=1 and no digitize.
REQ-038 Buffers 0..3 busy, next_ptr=0, clear buffer 2, then trigger: buffer 2 allocated, next_ptr=3.
REQ-039 holdoff_i=5 and edges at accept+1 and accept+6: the first is lost, the second is accepted; dead_o high for exactly 5 cycles.
REQ-040 trig_i=0110 with mask 0100: source=0100; trig_i held high for 20 cycles gives exactly one digitize.
REQ-041 With BUFMGR_DEADTIME_COUNTER_EN, all buffers busy for 100 cycles: dead_count_o=100; a clear of buffer 0 with all buffers free gives dead_count_o=0.
